// File: rtl/path_sequencer.sv
// Steps the robot through an 8-entry node path, one node per valid/ready handshake.
// Optional arrival watchdog enabled by defining PATH_SEQ_TIMEOUT_EN.
module path_sequencer #(
  parameter int                NODE_W      = 8,
  parameter logic [NODE_W-1:0] END_NODE    = 8'hFF,
  parameter int                TIMEOUT_CYC = 50000000,
  parameter int                CNT_W       = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              path_found,
  input  logic [31:0]       path0,
  input  logic [31:0]       path1,
  input  logic [31:0]       path2,
  input  logic [31:0]       path3,
  input  logic [31:0]       path4,
  input  logic [31:0]       path5,
  input  logic [31:0]       path6,
  input  logic [31:0]       path7,
  input  logic              abort,
  input  logic              node_ready,
  input  logic              arrived,
  output logic [NODE_W-1:0] node_out,
  output logic              node_valid,
  output logic [2:0]        node_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic [NODE_W-1:0] node_buf_q [8];
  logic [NODE_W-1:0] path_lo    [8];
  logic [NODE_W-1:0] node_out_q;
  logic              node_valid_q;
  logic [2:0]        node_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              pf_q;
  logic              pf_prev_q;

  logic              start_d;
  logic              can_start_d;
  logic [2:0]        idx_nxt_d;
  logic              last_entry_d;
  logic              timeout_hit_d;

  always_comb begin
    path_lo[0] = path0[NODE_W-1:0];
    path_lo[1] = path1[NODE_W-1:0];
    path_lo[2] = path2[NODE_W-1:0];
    path_lo[3] = path3[NODE_W-1:0];
    path_lo[4] = path4[NODE_W-1:0];
    path_lo[5] = path5[NODE_W-1:0];
    path_lo[6] = path6[NODE_W-1:0];
    path_lo[7] = path7[NODE_W-1:0];
  end

  // The edge detector looks at the registered copy, giving the two-cycle start latency.
  assign start_d      = pf_q & ~pf_prev_q;
  assign can_start_d  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign idx_nxt_d    = node_idx_q + 3'd1;
  assign last_entry_d = (node_idx_q == 3'd7) || (node_buf_q[idx_nxt_d] == END_NODE);

`ifdef PATH_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT so it always begins a wait from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout_hit_d = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  logic unused_hi;
  assign unused_hi = ^{path0[31:NODE_W], path1[31:NODE_W], path2[31:NODE_W], path3[31:NODE_W],
                       path4[31:NODE_W], path5[31:NODE_W], path6[31:NODE_W], path7[31:NODE_W]};
`else
  assign timeout_hit_d = 1'b0;

  logic unused_hi;
  assign unused_hi = ^{path0[31:NODE_W], path1[31:NODE_W], path2[31:NODE_W], path3[31:NODE_W],
                       path4[31:NODE_W], path5[31:NODE_W], path6[31:NODE_W], path7[31:NODE_W],
                       (TIMEOUT_CYC != 0), (CNT_W != 0)};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      node_out_q   <= '0;
      node_valid_q <= 1'b0;
      node_idx_q   <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      pf_q         <= 1'b0;
      pf_prev_q    <= 1'b0;
      for (int i = 0; i < 8; i++) node_buf_q[i] <= '0;
    end else begin
      pf_q      <= path_found;
      pf_prev_q <= pf_q;

      if (abort) begin
        state_q      <= S_IDLE;
        node_valid_q <= 1'b0;
        node_idx_q   <= 3'd0;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
      end else if (start_d && can_start_d) begin
        for (int i = 0; i < 8; i++) node_buf_q[i] <= path_lo[i];
        node_idx_q <= 3'd0;
        error_q    <= 1'b0;
        // An empty path completes without ever raising node_valid.
        if (path_lo[0] == END_NODE) begin
          state_q      <= S_DONE;
          node_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
        end else begin
          state_q      <= S_ISSUE;
          node_out_q   <= path_lo[0];
          node_valid_q <= 1'b1;
          busy_q       <= 1'b1;
          done_q       <= 1'b0;
        end
      end else begin
        case (state_q)
          S_ISSUE: begin
            if (node_valid_q && node_ready) begin
              state_q      <= S_WAIT;
              node_valid_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (arrived) begin
              if (last_entry_d) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q      <= S_ISSUE;
                node_idx_q   <= idx_nxt_d;
                node_out_q   <= node_buf_q[idx_nxt_d];
                node_valid_q <= 1'b1;
              end
            end else if (timeout_hit_d) begin
              state_q <= S_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign node_out   = node_out_q;
  assign node_valid = node_valid_q;
  assign node_idx   = node_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
